// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
package mem_arb_pkg;

   // Who owns the read data returning from the RAM this cycle
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_CPU_RD = 2'd1,
      OWN_DMA_RD = 2'd2
   } owner_t;

   localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter used for the optional arbiter statistics.
module arb_sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count enabled events, sticking at all-ones
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage (fixed
// priority) and a DMA/debug loader port. A starvation counter forces a DMA
// slot after STARVE_MAX consecutive denials; the CPU is stalled for that
// cycle. Defining MEM_ARB_STATS_EN adds saturating stall / DMA-grant counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_stall,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]   stall_cnt,
   output logic [15:0]   dgrant_cnt
`endif
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("mem_port_arbiter: STARVE_MAX must be >= 1");
   end

   logic [SW-1:0] starve_q, starve_d;
   owner_t        owner_q, owner_d;
   logic [DW-1:0] hold_q;
   logic [AW-1:0] addr_q;
   logic          cpu_gnt, dma_gnt;

   // Grant decision and starvation bookkeeping; DMA idle breaks the streak
   always_comb begin
      cpu_gnt  = 1'b0;
      dma_gnt  = 1'b0;
      starve_d = '0;
      if (c_req && d_req) begin
         if (starve_q == STARVE_LIM) begin
            dma_gnt = 1'b1;
         end else begin
            cpu_gnt  = 1'b1;
            starve_d = starve_q + SW'(1);
         end
      end else if (c_req) begin
         cpu_gnt = 1'b1;
      end else if (d_req) begin
         dma_gnt = 1'b1;
      end
   end

   // RAM-side mux, handshake outputs and next read owner
   always_comb begin
      m_we    = (cpu_gnt && c_we) || (dma_gnt && d_we);
      m_addr  = cpu_gnt ? c_addr : (dma_gnt ? d_addr : addr_q);
      m_wdata = dma_gnt ? d_wdata : c_wdata;
      c_stall = c_req && !cpu_gnt;
      d_gnt   = dma_gnt;
      owner_d = OWN_NONE;
      if (cpu_gnt && !c_we)
         owner_d = OWN_CPU_RD;
      else if (dma_gnt && !d_we)
         owner_d = OWN_DMA_RD;
   end

   // Read-data steering; CPU sees held data while it does not own the port
   always_comb begin
      c_rdata  = (owner_q == OWN_CPU_RD) ? m_rdata : hold_q;
      d_rvalid = (owner_q == OWN_DMA_RD);
      d_rdata  = m_rdata;
   end

   // Arbiter state: starvation count, read owner, last RAM address
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         starve_q <= '0;
         owner_q  <= OWN_NONE;
         addr_q   <= '0;
      end else begin
         starve_q <= starve_d;
         owner_q  <= owner_d;
         addr_q   <= m_addr;
      end
   end

   // Keep the last CPU load result so it survives stall and write cycles
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         hold_q <= '0;
      else if (owner_q == OWN_CPU_RD)
         hold_q <= m_rdata;
   end

`ifdef MEM_ARB_STATS_EN
   arb_sat_counter #(.W(16)) u_stall_cnt (
      .clock  (clock),
      .resetn (resetn),
      .inc    (c_stall),
      .count  (stall_cnt)
   );

   arb_sat_counter #(.W(16)) u_dgrant_cnt (
      .clock  (clock),
      .resetn (resetn),
      .inc    (d_gnt),
      .count  (dgrant_cnt)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural sync RAM.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          c_req = 1'b0, c_we = 1'b0;
   logic [AW-1:0] c_addr = '0;
   logic [DW-1:0] c_wdata = '0;
   logic          c_stall;
   logic [DW-1:0] c_rdata;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_v;
   int            n_cmp = 0;
   int            n_fail = 0;
   int            mstarve;
   logic          exp_g;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .c_req    (c_req),
      .c_we     (c_we),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_stall  (c_stall),
      .c_rdata  (c_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata)
   );

   always #5 clock = ~clock;

   // Single-port synchronous RAM, read-before-write
   always @(posedge clock) begin
      if (m_we) mem[m_addr[7:0]] <= m_wdata;
      m_rdata <= mem[m_addr[7:0]];
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      c_req = req; c_we = we; c_addr = a; c_wdata = wd;
   endtask

   task automatic dma(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      d_req = req; d_we = we; d_addr = a; d_wdata = wd;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cpu(0, 0, '0, '0);
      dma(0, 0, '0, '0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL reset_c_stall got %b want 0", c_stall); end
      n_cmp++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt got %b want 0", d_gnt); end
      n_cmp++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we got %b want 0", m_we); end
      n_cmp++; if (c_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_c_rdata got %h want 0", c_rdata); end
      n_cmp++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_d_rvalid got %b want 0", d_rvalid); end
      resetn = 1'b1;
   endtask

   task automatic test_preload();
      tick();
      dma(1, 1, 32'h10, 32'hDEADBEEF);
      @(negedge clock);
      n_cmp++; if (d_gnt !== 1'b1 || m_we !== 1'b1) begin n_fail++; $display("FAIL preload0 got gnt=%b we=%b want 1/1", d_gnt, m_we); end
      tick();
      dma(1, 1, 32'h30, 32'h12345678);
      @(negedge clock);
      n_cmp++; if (d_gnt !== 1'b1 || m_we !== 1'b1) begin n_fail++; $display("FAIL preload1 got gnt=%b we=%b want 1/1", d_gnt, m_we); end
      tick();
      dma(0, 0, '0, '0);
   endtask

   task automatic test_cpu_load();
      tick();
      cpu(1, 0, 32'h10, '0);
      @(negedge clock);
      n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_load_stall got %b want 0", c_stall); end
      n_cmp++; if (m_addr !== 32'h10) begin n_fail++; $display("FAIL cpu_load_addr got %h want 10", m_addr); end
      exp_q.push_back(32'hDEADBEEF);
      tick();
      cpu(0, 0, '0, '0);
      @(negedge clock);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_cmp++; if (c_rdata !== exp_v) begin n_fail++; $display("FAIL cpu_load_rdata got %h want %h", c_rdata, exp_v); end
      n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_load_stall2 got %b want 0", c_stall); end
   endtask

   task automatic test_starve();
      tick();
      cpu(1, 0, 32'h10, '0);
      dma(1, 1, 32'h40, 32'hA5);
      mstarve = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         exp_g = (mstarve == 4);
         n_cmp++; if (d_gnt !== exp_g) begin n_fail++; $display("FAIL starve_dgnt cyc %0d got %b want %b", i, d_gnt, exp_g); end
         n_cmp++; if (c_stall !== exp_g) begin n_fail++; $display("FAIL starve_stall cyc %0d got %b want %b", i, c_stall, exp_g); end
         n_cmp++; if (m_we !== exp_g) begin n_fail++; $display("FAIL starve_mwe cyc %0d got %b want %b", i, m_we, exp_g); end
         mstarve = exp_g ? 0 : mstarve + 1;
         tick();
      end
      cpu(0, 0, '0, '0);
      dma(0, 0, '0, '0);
   endtask

   task automatic test_dma_wr_rd();
      tick();
      dma(1, 1, 32'h20, 32'h55);
      @(negedge clock);
      n_cmp++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_wr_gnt got %b want 1", d_gnt); end
      n_cmp++; if (m_we !== 1'b1 || m_addr !== 32'h20) begin n_fail++; $display("FAIL dma_wr_port got we=%b addr=%h want 1/20", m_we, m_addr); end
      tick();
      dma(1, 0, 32'h20, '0);
      @(negedge clock);
      n_cmp++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_rd_gnt got %b want 1", d_gnt); end
      n_cmp++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL dma_rd_mwe got %b want 0", m_we); end
      n_cmp++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_wr_rvalid got %b want 0", d_rvalid); end
      exp_q.push_back(32'h55);
      tick();
      dma(0, 0, '0, '0);
      @(negedge clock);
      n_cmp++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL dma_rd_rvalid got %b want 1", d_rvalid); end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_cmp++; if (d_rdata !== exp_v) begin n_fail++; $display("FAIL dma_rd_rdata got %h want %h", d_rdata, exp_v); end
   endtask

   task automatic test_stall_hold();
      tick();
      cpu(1, 0, 32'h30, '0);
      dma(1, 1, 32'h44, 32'h99);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) c_addr = 32'h10;
         @(negedge clock);
         n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL hold_pre_stall cyc %0d got %b want 0", k, c_stall); end
         if (k > 0) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            n_cmp++; if (c_rdata !== exp_v) begin n_fail++; $display("FAIL hold_pre_rdata cyc %0d got %h want %h", k, c_rdata, exp_v); end
         end
         exp_q.push_back((k == 3) ? 32'hDEADBEEF : 32'h12345678);
         tick();
      end
      @(negedge clock);
      n_cmp++; if (c_stall !== 1'b1 || d_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_forced got stall=%b gnt=%b want 1/1", c_stall, d_gnt); end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_cmp++; if (c_rdata !== exp_v) begin n_fail++; $display("FAIL hold_stall_rdata got %h want %h", c_rdata, exp_v); end
      tick();
      dma(0, 0, '0, '0);
      @(negedge clock);
      n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL hold_post_stall got %b want 0", c_stall); end
      n_cmp++; if (c_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_post_rdata got %h want deadbeef", c_rdata); end
      exp_q.push_back(32'hDEADBEEF);
      tick();
      cpu(0, 0, '0, '0);
      @(negedge clock);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_cmp++; if (c_rdata !== exp_v) begin n_fail++; $display("FAIL hold_reload_rdata got %h want %h", c_rdata, exp_v); end
   endtask

   task automatic test_reset_mid();
      tick();
      dma(1, 0, 32'h20, '0);
      @(negedge clock);
      n_cmp++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt got %b want 1", d_gnt); end
      tick();
      cpu(1, 0, 32'h10, '0);
      dma(1, 0, 32'h30, '0);
      resetn = 1'b0;
      @(negedge clock);
      n_cmp++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid got %b want 0", d_rvalid); end
      tick();
      @(negedge clock);
      resetn = 1'b1;
      n_cmp++; if (dut.starve_q !== '0) begin n_fail++; $display("FAIL rmid_starve got %0d want 0", dut.starve_q); end
      n_cmp++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid2 got %b want 0", d_rvalid); end
      mstarve = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clock);
         exp_g = (mstarve == 4);
         n_cmp++; if (d_gnt !== exp_g) begin n_fail++; $display("FAIL rmid_slot cyc %0d got %b want %b", i, d_gnt, exp_g); end
         mstarve = exp_g ? 0 : mstarve + 1;
         tick();
      end
      cpu(0, 0, '0, '0);
      dma(0, 0, '0, '0);
      tick();
   endtask

   initial begin
      test_reset();
      test_preload();
      test_cpu_load();
      test_starve();
      test_dma_wr_rd();
      test_stall_hold();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
